// File: rtl/ins_prefetch.sv
// Instruction prefetch: sequential word fetch into imem, PC-tagged DEPTH-entry buffer, valid/ready out.
// Latency: request at t, 1-cycle imem responds at t+1, instruction presented from t+2; 1 instr/cycle sustained.
// Backpressure: issue stops once outstanding requests plus buffered entries reach DEPTH; head holds while !ins_ready.

// Small synchronous FIFO with flush; head data is raw storage, the caller qualifies it with count.
module pf_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [W-1:0]               push_dat_i,
    input  logic                       pop_i,
    output logic [W-1:0]               head_dat_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] rd_q, rd_d;
    logic [PW-1:0] wr_q, wr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Pointer and occupancy next-state; flush empties the buffer and voids any same-cycle push/pop.
    always_comb begin
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        if (flush_i) begin
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end else begin
            if (push_i) wr_d = wr_q + PW'(1);
            if (pop_i)  rd_d = rd_q + PW'(1);
            cnt_d = cnt_q + CW'(push_i) - CW'(pop_i);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    // Entry storage; contents are don't-care until written, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) begin
            mem_q[wr_q] <= push_dat_i;
        end
    end

    assign head_dat_o = mem_q[rd_q];
    assign count_o    = cnt_q;
endmodule

module ins_prefetch #(
    parameter int DEPTH = 4,
    parameter int AW    = 8,
    parameter int IW    = 32
) (
    input  logic                       clk,
    input  logic                       rstd,
    output logic                       imem_req,
    output logic [AW-1:0]              imem_addr,
    input  logic [IW-1:0]              imem_rdata,
    input  logic                       imem_rvalid,
    input  logic                       redirect,
    input  logic [31:0]                redirect_pc,
    output logic                       ins_valid,
    output logic [IW-1:0]              ins,
    output logic [31:0]                ins_pc,
    input  logic                       ins_ready,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [IW-1:0] ins;
        logic [31:0]   pc;
    } entry_t;

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   resp_pc_q,  resp_pc_d;
    logic [CW-1:0] outst_q,    outst_d;
    logic [CW-1:0] discard_q,  discard_d;

    logic [CW:0]   inflight;
    logic          resp_drop;
    logic          push;
    logic          pop;
    entry_t        push_ent;
    entry_t        head_ent;

    // Credits: every request in flight already owns a buffer slot, so a push can never overflow.
    assign inflight  = {1'b0, outst_q} + {1'b0, count};
    assign imem_req  = !rstd && !redirect && (inflight < (CW+1)'(DEPTH));
    assign imem_addr = fetch_pc_q[AW-1:0];

    assign resp_drop = imem_rvalid && (discard_q != '0);
    assign push      = imem_rvalid && !resp_drop && !redirect;
    assign pop       = ins_valid && ins_ready && !redirect;
    assign push_ent  = '{ins: imem_rdata, pc: resp_pc_q};

    pf_fifo #(
        .W     ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rstd),
        .flush_i    (redirect),
        .push_i     (push),
        .push_dat_i (push_ent),
        .pop_i      (pop),
        .head_dat_o (head_ent),
        .count_o    (count)
    );

    assign ins_valid = (count != '0);
    assign ins       = ins_valid ? head_ent.ins : '0;
    assign ins_pc    = ins_valid ? head_ent.pc  : '0;

    // Fetch/response PC, in-flight and discard bookkeeping; redirect overrides everything else.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        outst_d    = outst_q + CW'(imem_req) - CW'(imem_rvalid);
        discard_d  = discard_q;
        if (imem_req)  fetch_pc_d = fetch_pc_q + 32'd1;
        if (push)      resp_pc_d  = resp_pc_q + 32'd1;
        if (resp_drop) discard_d  = discard_q - CW'(1);
        if (redirect) begin
            fetch_pc_d = redirect_pc;
            resp_pc_d  = redirect_pc;
            // Every request still in flight is now stale; any already marked for discard is part of
            // outstanding, so back-to-back redirects never over-count and swallow good responses.
            discard_d  = outst_q - CW'(imem_rvalid);
        end
    end

    // Control state registers.
    always_ff @(posedge clk or posedge rstd) begin
        if (rstd) begin
            fetch_pc_q <= '0;
            resp_pc_q  <= '0;
            outst_q    <= '0;
            discard_q  <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            outst_q    <= outst_d;
            discard_q  <= discard_d;
        end
    end
endmodule

// File: tb/tb_ins_prefetch.sv
module tb_ins_prefetch;
    logic        clk;
    logic        rstd;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_rvalid;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        ins_valid;
    logic [31:0] ins;
    logic [31:0] ins_pc;
    logic        ins_ready;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;
    int lat    = 1;

    ins_prefetch #(.DEPTH(4), .AW(8), .IW(32)) dut (
        .clk         (clk),
        .rstd        (rstd),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_rvalid (imem_rvalid),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .ins_valid   (ins_valid),
        .ins         (ins),
        .ins_pc      (ins_pc),
        .ins_ready   (ins_ready),
        .count       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory model: mem[a] = a, fixed latency 'lat' (1..3), responses in order.
    logic [2:0] pv;
    logic [7:0] pa [3];
    always @(posedge clk or posedge rstd) begin
        if (rstd) begin
            pv    <= '0;
            pa[0] <= '0;
            pa[1] <= '0;
            pa[2] <= '0;
        end else begin
            pv    <= {pv[1:0], imem_req};
            pa[0] <= imem_addr;
            pa[1] <= pa[0];
            pa[2] <= pa[1];
        end
    end
    assign imem_rvalid = pv[lat-1];
    assign imem_rdata  = {24'd0, pa[lat-1]};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Holds reset two cycles, releases at a falling edge: caller is then at the start of cycle 0.
    task automatic do_reset(input int l, input logic rdy);
        rstd      = 1'b1;
        redirect  = 1'b0;
        redirect_pc = '0;
        ins_ready = rdy;
        lat       = l;
        repeat (2) @(negedge clk);
        rstd = 1'b0;
    endtask

    // Waits (bounded) for ins_valid; n = cycles waited. Called at falling edge + 1.
    task automatic wait_vld(input string name, input int max, output int n);
        n = 0;
        while (!ins_valid && n < max) begin
            @(negedge clk); #1;
            n++;
        end
        if (!ins_valid) chk({name, "_timeout"}, 32'(ins_valid), 32'd1);
    endtask

    typedef struct {
        logic        rdy;
        logic        vld;
        logic [31:0] pc;
        logic [2:0]  cnt;
        logic        req;
    } vec_t;

    vec_t tbl [22];
    int   n;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Streaming with ready=1, then 10 cycles of ready=0, then drain.
        tbl[0]  = '{1'b1, 1'b0, 32'd0, 3'd0, 1'b1};
        tbl[1]  = '{1'b1, 1'b0, 32'd0, 3'd0, 1'b1};
        tbl[2]  = '{1'b1, 1'b1, 32'd0, 3'd1, 1'b1};
        tbl[3]  = '{1'b1, 1'b1, 32'd1, 3'd1, 1'b1};
        tbl[4]  = '{1'b1, 1'b1, 32'd2, 3'd1, 1'b1};
        tbl[5]  = '{1'b1, 1'b1, 32'd3, 3'd1, 1'b1};
        tbl[6]  = '{1'b0, 1'b1, 32'd4, 3'd1, 1'b1};
        tbl[7]  = '{1'b0, 1'b1, 32'd4, 3'd2, 1'b1};
        tbl[8]  = '{1'b0, 1'b1, 32'd4, 3'd3, 1'b0};
        for (int i = 9; i <= 15; i++) tbl[i] = '{1'b0, 1'b1, 32'd4, 3'd4, 1'b0};
        tbl[16] = '{1'b1, 1'b1, 32'd4, 3'd4, 1'b0};
        tbl[17] = '{1'b1, 1'b1, 32'd5, 3'd3, 1'b1};
        tbl[18] = '{1'b1, 1'b1, 32'd6, 3'd2, 1'b1};
        tbl[19] = '{1'b1, 1'b1, 32'd7, 3'd2, 1'b1};
        tbl[20] = '{1'b1, 1'b1, 32'd8, 3'd2, 1'b1};
        tbl[21] = '{1'b1, 1'b1, 32'd9, 3'd2, 1'b1};

        // Reset values while rstd is held.
        rstd = 1'b1; redirect = 1'b0; redirect_pc = '0; ins_ready = 1'b1;
        #1;
        chk("rst_req",   32'(imem_req),  32'd0);
        chk("rst_valid", 32'(ins_valid), 32'd0);
        chk("rst_ins",   ins,            32'd0);
        chk("rst_pc",    ins_pc,         32'd0);
        chk("rst_count", 32'(count),     32'd0);

        // Streaming and backpressure vectors.
        do_reset(1, 1'b1);
        for (int i = 0; i < 22; i++) begin
            ins_ready = tbl[i].rdy;
            #1;
            chk($sformatf("vec%0d_valid", i), 32'(ins_valid), 32'(tbl[i].vld));
            chk($sformatf("vec%0d_pc", i),    ins_pc,         tbl[i].vld ? tbl[i].pc : 32'd0);
            chk($sformatf("vec%0d_ins", i),   ins,            tbl[i].vld ? {24'd0, tbl[i].pc[7:0]} : 32'd0);
            chk($sformatf("vec%0d_count", i), 32'(count),     32'(tbl[i].cnt));
            chk($sformatf("vec%0d_req", i),   32'(imem_req),  32'(tbl[i].req));
            @(negedge clk);
        end

        // 3-cycle imem: redirect to 0x40 with 3 requests outstanding, one arriving that cycle.
        do_reset(3, 1'b1);
        repeat (3) @(negedge clk);
        redirect = 1'b1; redirect_pc = 32'h40;
        #1;
        chk("t3_req_during_redirect", 32'(imem_req), 32'd0);
        @(negedge clk);
        redirect = 1'b0;
        #1;
        chk("t3_addr", 32'(imem_addr), 32'h40);
        chk("t3_req",  32'(imem_req),  32'd1);
        wait_vld("t3", 20, n);
        chk("t3_latency", n, 32'd4);
        chk("t3_pc0",  ins_pc, 32'h40);
        chk("t3_ins0", ins,    32'h40);
        @(negedge clk); #1;
        chk("t3_pc1",  ins_pc, 32'h41);
        chk("t3_ins1", ins,    32'h41);

        // Redirect coincident with an arriving response and a pop.
        do_reset(1, 1'b1);
        repeat (4) @(negedge clk);
        redirect = 1'b1; redirect_pc = 32'h80;
        #1;
        chk("t4_pre_valid", 32'(ins_valid), 32'd1);
        chk("t4_pre_req",   32'(imem_req),  32'd0);
        @(negedge clk);
        redirect = 1'b0;
        #1;
        chk("t4_valid", 32'(ins_valid), 32'd0);
        chk("t4_count", 32'(count),     32'd0);
        chk("t4_ins",   ins,            32'd0);
        chk("t4_pc",    ins_pc,         32'd0);
        chk("t4_addr",  32'(imem_addr), 32'h80);
        wait_vld("t4", 20, n);
        chk("t4_latency", n, 32'd2);
        chk("t4_first_pc",  ins_pc, 32'h80);
        chk("t4_first_ins", ins,    32'h80);

        // Back-to-back redirects with stale requests in flight: the last target wins.
        do_reset(3, 1'b1);
        repeat (2) @(negedge clk);
        redirect = 1'b1; redirect_pc = 32'h10;
        @(negedge clk);
        redirect_pc = 32'h20;
        @(negedge clk);
        redirect = 1'b0;
        #1;
        chk("t4b_addr", 32'(imem_addr), 32'h20);
        wait_vld("t4b", 20, n);
        chk("t4b_latency", n, 32'd4);
        chk("t4b_pc0",  ins_pc, 32'h20);
        chk("t4b_ins0", ins,    32'h20);
        @(negedge clk); #1;
        chk("t4b_pc1",  ins_pc, 32'h21);
        chk("t4b_ins1", ins,    32'h21);

        // 32-bit PC wrap and AW-bit address wrap.
        do_reset(1, 1'b1);
        repeat (3) @(negedge clk);
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE;
        @(negedge clk);
        redirect = 1'b0;
        #1;
        chk("t5_addr0", 32'(imem_addr), 32'hFE);
        @(negedge clk); #1;
        chk("t5_addr1", 32'(imem_addr), 32'hFF);
        @(negedge clk); #1;
        chk("t5_addr2", 32'(imem_addr), 32'h00);
        chk("t5_pc0",   ins_pc, 32'hFFFF_FFFE);
        chk("t5_ins0",  ins,    32'hFE);
        @(negedge clk); #1;
        chk("t5_pc1",   ins_pc, 32'hFFFF_FFFF);
        chk("t5_ins1",  ins,    32'hFF);
        @(negedge clk); #1;
        chk("t5_valid2", 32'(ins_valid), 32'd1);
        chk("t5_pc2",   ins_pc, 32'h0);
        chk("t5_ins2",  ins,    32'h0);

        // Asynchronous reset mid-cycle with a full buffer.
        do_reset(1, 1'b0);
        repeat (6) @(negedge clk);
        #1;
        chk("t6_full", 32'(count), 32'd4);
        #2;
        rstd = 1'b1;
        #1;
        chk("t6_valid", 32'(ins_valid), 32'd0);
        chk("t6_ins",   ins,            32'd0);
        chk("t6_pc",    ins_pc,         32'd0);
        chk("t6_count", 32'(count),     32'd0);
        chk("t6_req",   32'(imem_req),  32'd0);
        @(negedge clk);
        rstd = 1'b0; ins_ready = 1'b1;
        #1;
        chk("t6_addr", 32'(imem_addr), 32'd0);
        wait_vld("t6", 20, n);
        chk("t6_latency", n, 32'd2);
        chk("t6_pc0", ins_pc, 32'd0);
        @(negedge clk); #1;
        chk("t6_pc1", ins_pc, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
